// File: rtl/seq_detect_pkg.sv
// ============================================================================
//  Module      : seq_detect_pkg
//  Description : Shared defaults, fill-width helper and parameter legality
//                checks for the seq_detect_param serial pattern detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_detect_pkg;

    localparam int         SEQ_PAT_W_DEFAULT   = 4;
    localparam logic [3:0] SEQ_PATTERN_DEFAULT = 4'b1001;
    localparam int         SEQ_CNT_W_DEFAULT   = 8;

    // fill counts 0..PAT_W-1, so $clog2(PAT_W) bits always suffice
    function automatic int seq_fill_w(input int pat_w);
        return $clog2(pat_w);
    endfunction

    function automatic bit seq_pat_w_ok(input int pat_w);
        return (pat_w >= 2) && (pat_w <= 32);
    endfunction

    function automatic bit seq_cnt_w_ok(input int cnt_w);
        return (cnt_w >= 1) && (cnt_w <= 32);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_match_counter.sv
// ============================================================================
//  Module      : seq_match_counter
//  Description : CNT_W-bit saturating event counter with synchronous clear
//                and asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_match_counter
    import seq_detect_pkg::*;
#(
    parameter int CNT_W = SEQ_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/seq_detect_param.sv
// ============================================================================
//  Module      : seq_detect_param
//  Description : Parametrised serial bit-pattern detector, overlapping or
//                non-overlapping mode; SEQ_DETECT_COUNT_EN adds match_count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = SEQ_PAT_W_DEFAULT,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_PATTERN_DEFAULT),
    parameter int               CNT_W   = SEQ_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inp_valid,
    input  logic             inp_bit,
    input  logic             overlap_en,
    input  logic             clear,
    output logic             seq_seen
`ifdef SEQ_DETECT_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    localparam int               c_FILL_W    = seq_fill_w(PAT_W);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PAT_W - 1);

    if (!seq_pat_w_ok(PAT_W) || !seq_cnt_w_ok(CNT_W)) begin : g_bad_params
        $error("seq_detect_param: PAT_W must be 2..32 and CNT_W 1..32");
    end

    logic [PAT_W-2:0]    r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic                r_seen;
    logic [PAT_W-1:0]    w_window;
    logic                w_match;

    assign w_window = {r_hist, inp_bit};
    assign w_match  = inp_valid && (r_fill == c_FILL_FULL) && (w_window == PATTERN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_seen <= 1'b0;
        end else if (clear) begin
            r_hist <= '0;
            r_fill <= '0;
            r_seen <= 1'b0;
        end else if (inp_valid) begin
            r_hist <= w_window[PAT_W-2:0];
            r_seen <= w_match;
            if (w_match) begin
                // non-overlap mode discards the matched bits entirely
                r_fill <= overlap_en ? c_FILL_FULL : '0;
            end else if (r_fill != c_FILL_FULL) begin
                r_fill <= r_fill + 1'b1;
            end
        end else begin
            r_seen <= 1'b0;
        end
    end

    assign seq_seen = r_seen;

`ifdef SEQ_DETECT_COUNT_EN
    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clear (clear),
        .i_inc   (w_match),
        .o_count (match_count)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_param.sv
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Directed self-checking bench for seq_detect_param.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_param;

    logic clk = 1'b0;
    logic reset;
    logic inp_valid;
    logic inp_bit;
    logic overlap_en;
    logic clear;
    logic seen_d;
    logic seen_6;
    logic seen_s;
`ifdef SEQ_DETECT_COUNT_EN
    logic [7:0] cnt_d;
    logic [7:0] cnt_6;
    logic [1:0] cnt_s;
`endif

    always #5 clk = ~clk;

    seq_detect_param u_dut (
        .clk        (clk),
        .reset      (reset),
        .inp_valid  (inp_valid),
        .inp_bit    (inp_bit),
        .overlap_en (overlap_en),
        .clear      (clear),
        .seq_seen   (seen_d)
`ifdef SEQ_DETECT_COUNT_EN
        ,
        .match_count(cnt_d)
`endif
    );

    seq_detect_param #(
        .PAT_W   (6),
        .PATTERN (6'b110110),
        .CNT_W   (8)
    ) u_dut6 (
        .clk        (clk),
        .reset      (reset),
        .inp_valid  (inp_valid),
        .inp_bit    (inp_bit),
        .overlap_en (overlap_en),
        .clear      (clear),
        .seq_seen   (seen_6)
`ifdef SEQ_DETECT_COUNT_EN
        ,
        .match_count(cnt_6)
`endif
    );

    seq_detect_param #(
        .PAT_W   (4),
        .PATTERN (4'b1111),
        .CNT_W   (2)
    ) u_sat (
        .clk        (clk),
        .reset      (reset),
        .inp_valid  (inp_valid),
        .inp_bit    (inp_bit),
        .overlap_en (overlap_en),
        .clear      (clear),
        .seq_seen   (seen_s)
`ifdef SEQ_DETECT_COUNT_EN
        ,
        .match_count(cnt_s)
`endif
    );

    typedef struct {
        logic valid;
        logic bitv;
        logic ovl;
        logic clr;
        logic exp_seen;
        int   exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic b, input logic o, input logic c,
                       input logic es, input int ec);
        vec_t r;
        r.valid = v; r.bitv = b; r.ovl = o; r.clr = c; r.exp_seen = es; r.exp_cnt = ec;
        vecs.push_back(r);
    endtask

    // apply one cycle of inputs, then look at outputs 1 time unit after the edge
    task automatic drive(input logic v, input logic b, input logic o, input logic c);
        inp_valid = v; inp_bit = b; overlap_en = o; clear = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] bits6;
        logic [8:0] exp6;

        reset = 1'b0; inp_valid = 1'b0; inp_bit = 1'b0; overlap_en = 1'b0; clear = 1'b0;

        // held in reset with a full pattern on the input: nothing may happen
        bits6 = 9'b100110010;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, bits6[8-i], i[0], 1'b0);
            check("rst_hold_seen", i, 32'(seen_d), 32'd0);
`ifdef SEQ_DETECT_COUNT_EN
            check("rst_hold_cnt", i, 32'(cnt_d), 32'd0);
`endif
        end

        // release mid-cycle; 1001 pulses exactly one cycle after bit 4
        reset = 1'b1;
        bits6 = 9'b000001001;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bits6[3-i], 1'b0, 1'b0);
            check("post_rst_seen", i, 32'(seen_d), (i == 3) ? 32'd1 : 32'd0);
        end
`ifdef SEQ_DETECT_COUNT_EN
        check("post_rst_cnt", 0, 32'(cnt_d), 32'd1);
`endif
        // an asserted pulse drops asynchronously with reset
        #2 reset = 1'b0;
        #1;
        check("async_drop_seen", 0, 32'(seen_d), 32'd0);
`ifdef SEQ_DETECT_COUNT_EN
        check("async_drop_cnt", 0, 32'(cnt_d), 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;

        // reset pulse mid-pattern discards the partial 100
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("midrst_seen", 0, 32'(seen_d), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("midrst_seen", 1, 32'(seen_d), 32'd1);

        // ---- default-pattern (1001) vector table ----
        // non-overlap on 1001001: one pulse
        add(1,0,0,1, 0,0);
        add(1,1,0,0, 0,0); add(1,0,0,0, 0,0); add(1,0,0,0, 0,0); add(1,1,0,0, 1,1);
        add(1,0,0,0, 0,1); add(1,0,0,0, 0,1); add(1,1,0,0, 0,1);
        // overlap on 1001001: pulses after bits 4 and 7
        add(1,0,1,1, 0,0);
        add(1,1,1,0, 0,0); add(1,0,1,0, 0,0); add(1,0,1,0, 0,0); add(1,1,1,0, 1,1);
        add(1,0,1,0, 0,1); add(1,0,1,0, 0,1); add(1,1,1,0, 1,2); add(0,1,1,0, 0,2);
        // gaps: 1,0, five idle cycles, 0,1
        add(1,0,1,1, 0,0);
        add(1,1,1,0, 0,0); add(1,0,1,0, 0,0);
        add(0,1,1,0, 0,0); add(0,1,1,0, 0,0); add(0,1,1,0, 0,0); add(0,0,1,0, 0,0);
        add(0,1,1,0, 0,0);
        add(1,0,1,0, 0,0); add(1,1,1,0, 1,1);
        // partial-prefix recovery: 11001
        add(1,0,0,1, 0,0);
        add(1,1,0,0, 0,0); add(1,1,0,0, 0,0); add(1,0,0,0, 0,0); add(1,0,0,0, 0,0);
        add(1,1,0,0, 1,1); add(0,0,0,0, 0,1);
        // clear coincident with a match edge wins; search restarts from scratch
        add(1,0,1,1, 0,0);
        add(1,1,1,0, 0,0); add(1,0,1,0, 0,0); add(1,0,1,0, 0,0); add(1,1,1,1, 0,0);
        add(1,0,1,0, 0,0); add(1,0,1,0, 0,0); add(1,1,1,0, 0,0); add(1,1,1,0, 0,0);
        // overlap_en matters only on the match edge
        add(1,0,0,1, 0,0);
        add(1,1,0,0, 0,0); add(1,0,0,0, 0,0); add(1,0,0,0, 0,0); add(1,1,1,0, 1,1);
        add(1,0,0,0, 0,1); add(1,0,0,0, 0,1); add(1,1,0,0, 1,2);
        add(1,0,1,0, 0,2); add(1,0,1,0, 0,2); add(1,1,1,0, 0,2);

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].bitv, vecs[i].ovl, vecs[i].clr);
            check("tbl_seen", i, 32'(seen_d), 32'(vecs[i].exp_seen));
`ifdef SEQ_DETECT_COUNT_EN
            check("tbl_cnt", i, 32'(cnt_d), 32'(vecs[i].exp_cnt));
`endif
        end

        // PAT_W=6, 110110, overlap on 110110110: pulses after bits 6 and 9
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        bits6 = 9'b110110110;
        exp6  = 9'b000001001;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, bits6[8-i], 1'b1, 1'b0);
            check("pat6_seen", i, 32'(seen_6), 32'(exp6[8-i]));
        end
`ifdef SEQ_DETECT_COUNT_EN
        check("pat6_cnt", 0, 32'(cnt_6), 32'd2);
`endif

        // CNT_W=2, 1111 on eight ones: continuous pulse, count saturates at 3
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            check("sat_seen", i, 32'(seen_s), (i >= 3) ? 32'd1 : 32'd0);
`ifdef SEQ_DETECT_COUNT_EN
            check("sat_cnt", i, 32'(cnt_s), (i < 3) ? 32'd0 : ((i - 2 > 3) ? 32'd3 : 32'(i - 2)));
`endif
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("sat_clr_seen", 0, 32'(seen_s), 32'd0);
`ifdef SEQ_DETECT_COUNT_EN
        check("sat_clr_cnt", 0, 32'(cnt_s), 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            check("sat_refill_seen", i, 32'(seen_s), (i == 3) ? 32'd1 : 32'd0);
        end
`ifdef SEQ_DETECT_COUNT_EN
        check("sat_refill_cnt", 0, 32'(cnt_s), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector, the generalised successor of the fixed 1001 detector. It detects an arbitrary PAT_W-bit pattern on a qualified serial input, in a runtime-selectable overlapping or non-overlapping mode. It emits a one-cycle registered match pulse and, optionally, a saturating match count. It sits in the serial-input front end and feeds match events to downstream control logic.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..32
- PATTERN, 4'b1001, PAT_W-bit pattern; MSB is the first bit received
- CNT_W, 8, width of match_count; legal range 1..32
- clk  input  1  clock, rising-edge active
- reset  input  1  asynchronous, active-low reset; asserting it (0) resets all state immediately
- inp_valid  input  1  qualifies inp_bit; the bit is sampled only when this is 1
- inp_bit  input  1  serial data bit
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
- clear  input  1  synchronous soft clear of detector state and count
- seq_seen  output  1  registered match pulse, one cycle wide per match
- match_count  output  CNT_W  saturating number of matches since reset/clear (SEQ_DETECT_COUNT_EN only)

## Operation
- State:
  - hist: PAT_W-1 bits holding the most recent valid bits.
  - fill: 0..PAT_W-1, the number of bits in hist that belong to the current search.
- Window on a valid sample: {hist, inp_bit}.
- Match: inp_valid=1 AND fill==PAT_W-1 AND window==PATTERN.
- Valid sample, no match:
  - Shift inp_bit into hist.
  - fill <= min(fill+1, PAT_W-1).
- Valid sample, match, overlap_en=1:
  - Shift inp_bit into hist.
  - fill stays PAT_W-1, so the matched bits can start the next match.
- Valid sample, match, overlap_en=0:
  - Set fill <= 0. The matched bits are discarded and the next match needs PAT_W fresh bits.
  - hist still shifts; its content is don't-care while fill<PAT_W-1.
- inp_valid=0: hist and fill hold; seq_seen <= 0.
- clear=1, highest synchronous priority:
  - hist <= 0, fill <= 0, seq_seen <= 0, match_count <= 0.
  - The concurrent inp_bit is ignored.
- overlap_en is sampled only on the edge where a match occurs. Changing it between matches has no other effect.
- match_count increments by 1 on each match edge and saturates at 2^CNT_W-1 (no wrap).
- Reset values, applied immediately while reset=0: hist=0, fill=0, seq_seen=0, match_count=0.

## Timing
- Latency: seq_seen is high in the cycle following the rising edge that samples the completing bit.
- seq_seen is high for exactly one cycle per match.
- With back-to-back matches (overlap mode, e.g. PATTERN=1111 on an all-ones input), seq_seen stays high continuously, one match per cycle.
- match_count updates on the same edge that sets seq_seen.
- When reset is deasserted (0 to 1), the first sample is taken on the next rising edge; that sample can at most reach fill=1.
- Asserting reset mid-pattern discards the partial pattern. A pulse already high falls asynchronously.
- clear and a match on the same edge: clear wins. No pulse and no count.

## Configuration
- SEQ_DETECT_COUNT_EN defined:
  - The match_count port and the saturating counter are present.
- SEQ_DETECT_COUNT_EN undefined:
  - The match_count port is absent and no counter logic is generated.
  - clear still resets hist, fill and seq_seen.
- Detection behaviour and seq_seen timing are identical in both builds.

## Structure
- Shared package seq_detect_pkg holds:
  - SEQ_PAT_W_DEFAULT = 4
  - SEQ_PATTERN_DEFAULT = 4'b1001
  - SEQ_CNT_W_DEFAULT = 8
  - the function for fill width, $clog2(PAT_W)
  - the elaboration-time legality checks for PAT_W and CNT_W
- Sub-module seq_match_counter: CNT_W saturating counter with sync clear, inc input, and async active-low reset. Instantiated only under SEQ_DETECT_COUNT_EN.

## Test plan
- Reset: hold reset=0 while toggling inputs -> seq_seen=0 and match_count=0 throughout. After release, feed 1001 -> seq_seen=1 exactly one cycle after the 4th bit.
- Overlap off vs on, input 1001001:
  - overlap_en=0 -> one pulse (after bit 4); match_count=1.
  - overlap_en=1 -> pulses after bits 4 and 7; match_count=2.
- Gaps: feed 1,0 then inp_valid=0 for 5 cycles, then 0,1 -> one pulse after the final bit. No pulse during the idle cycles.
- Partial-prefix recovery: input 11001, default pattern -> one pulse after bit 5.
- PAT_W=6, PATTERN=6'b110110, overlap_en=1, input 110110110 -> pulses after bits 6 and 9.
- Saturation and clear, CNT_W=2, overlap_en=1, PATTERN=4'b1111, 8 ones:
  - count goes 1,2,3,3,3.
  - clear asserted on a match edge -> no pulse, count=0, and the next match needs 4 fresh ones.
